instr_loader: RTL

Program loader for the writable instruction memory. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word-aligned byte addresses starting at 0. Pads the unused tail with a fill word. Holds the CPU stalled until the image is fully committed. Sits between the bench/host stream source and the instruction RAM, replacing file-based ROM initialisation with run-time loading.

---
 rtl/instr_load_pkg.sv | 22 ++
 rtl/instructmem_rw.sv | 48 ++++
 rtl/instr_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/instr_load_pkg.sv
// Shared types and defaults for the run-time instruction image loader.
package instr_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE,
        ST_ERR
    } load_state_t;

    localparam int          MEM_SIZE_DEFAULT  = 1024;
    localparam int          DEPTH_DEFAULT     = MEM_SIZE_DEFAULT / 4;
    localparam int          PTR_W_DEFAULT     = $clog2(DEPTH_DEFAULT) + 1;
    localparam logic [31:0] FILL_WORD_DEFAULT = 32'h0000_0000;

    // Word index to word-aligned byte address.
    function automatic logic [63:0] word_to_byte_addr(input logic [63:0] word_idx);
        return word_idx << 2;
    endfunction

endpackage

// File: rtl/instructmem_rw.sv
// Writable instruction RAM: one registered write port, one combinational read port.
// Reads behave like the old ROM: word-aligned, and anything touching bytes past
// the end of memory returns X.
module instructmem_rw
    import instr_load_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT
)(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [63:0] rd_addr,
    output logic [31:0] rd_data
);

    localparam int          DEPTH     = MEM_SIZE / 4;
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE);

    logic [31:0] mem [DEPTH];

    // Commit one word per enabled cycle; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < MEM_BYTES)) begin
            mem[wr_addr[AW+1:2]] <= wr_data;
        end
    end

    // Sanity checks on address alignment and write bounds.
    always @(posedge clk) begin
        if (wr_en) begin
            assert (wr_addr[1:0] == 2'b00);
            assert (wr_addr < MEM_BYTES);
        end
        assert (rd_addr[1:0] == 2'b00);
    end

    // Combinational read; a word whose last byte lies past the end reads as X.
    always_comb begin
        if (rd_addr >= (MEM_BYTES - 64'd3)) begin
            rd_data = 'x;
        end else begin
            rd_data = mem[rd_addr[AW+1:2]];
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams an instruction image into the writable instruction RAM, pads the
// remainder with FILL_WORD and keeps the CPU held until the last write commits.
module instr_loader
    import instr_load_pkg::*;
#(
    parameter int          MEM_SIZE  = MEM_SIZE_DEFAULT,
    parameter logic [31:0] FILL_WORD = FILL_WORD_DEFAULT
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [31:0]                  in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic [63:0]                  wr_addr,
    output logic [31:0]                  wr_data,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(MEM_SIZE/4):0]  word_count,
    output logic [31:0]                  checksum
);

    localparam int               DEPTH   = MEM_SIZE / 4;
    localparam int               PTR_W   = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    load_state_t      state;
    logic [PTR_W-1:0] ptr;

    // Loader FSM with registered outputs. done/cpu_hold change one edge after
    // entering DONE, i.e. at the edge that commits the final RAM write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (state == ST_DONE) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                    if (start) begin
                        state      <= ST_LOAD;
                        ptr        <= '0;
                        word_count <= '0;
                        checksum   <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                        in_ready   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (ptr == DEPTH_C) begin
                            state    <= ST_ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            wr_en      <= 1'b1;
                            wr_addr    <= word_to_byte_addr(64'(ptr));
                            wr_data    <= in_data;
                            ptr        <= ptr + 1'b1;
                            word_count <= word_count + 1'b1;
                            checksum   <= checksum + in_data;
                            if (in_last) begin
                                in_ready <= 1'b0;
                                state    <= (ptr == LAST_C) ? ST_DONE : ST_FILL;
                            end
                        end
                    end
                end
                ST_FILL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= word_to_byte_addr(64'(ptr));
                    wr_data <= FILL_WORD;
                    ptr     <= ptr + 1'b1;
                    if (ptr == LAST_C) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
